// File: rtl/ifsram_pkg.sv
// Shared definitions for the ifsram write/read stages: widths, FSM encodings,
// row-state codes and the row-size helper.
package ifsram_pkg;

   localparam int TBITS         = 64;
   localparam int TBYTE         = TBITS / 8;
   localparam int ADDR_W        = 11;
   localparam int NUM_ROW_SLOTS = 3;

   typedef enum logic [1:0] {
      IW_IDLE  = 2'd0,
      IW_WRITE = 2'd1,
      IW_DONE  = 2'd2
   } iw_state_e;

   typedef enum logic [2:0] {
      UP_PADDING   = 3'd0,
      THREEROW     = 3'd1,
      TWOROW       = 3'd2,
      ONEROW       = 3'd3,
      DOWN_PADDING = 3'd4
   } row_state_e;

   // Words occupied by one feature row: W windows * 3 columns * C channel words.
   function automatic logic [ADDR_W-1:0] row_words(input logic [3:0] w, input logic [4:0] c);
      return ADDR_W'(w) * ADDR_W'(c) * ADDR_W'(3);
   endfunction

endpackage

// File: rtl/ifsram_w_addr_gen.sv
// Address generator for the ifsram write stage: ch/col/win/row counter chain,
// circular row-slot selection and the per-row base address register.
module ifsram_w_addr_gen
   import ifsram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic              step,
   input  logic [3:0]        cfg_window,
   input  logic [4:0]        cfg_atlchin,
   input  logic [1:0]        cfg_row_cnt,
   input  logic [1:0]        cfg_start_slot,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [3:0]        ch_q, ch_d, win_q, win_d;
   logic [3:0]        c_max_q, c_max_d, w_max_q, w_max_d;
   logic [1:0]        col_q, col_d, row_q, row_d;
   logic [1:0]        r_max_q, r_max_d, slot_q, slot_d;
   logic [ADDR_W-1:0] off_q, off_d, base_q, base_d, words_q, words_d;
   logic [ADDR_W-1:0] init_words;
   logic              ch_end, col_end, win_end, row_end;

   assign init_words = row_words(cfg_window, cfg_atlchin);
   assign ch_end     = (ch_q == c_max_q);
   assign col_end    = (col_q == 2'd2);
   assign win_end    = (win_q == w_max_q);
   assign row_end    = (row_q == r_max_q);
   assign last       = ch_end & col_end & win_end & row_end;
   assign addr       = base_q + off_q;

   // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      ch_d    = ch_q;
      col_d   = col_q;
      win_d   = win_q;
      row_d   = row_q;
      off_d   = off_q;
      slot_d  = slot_q;
      base_d  = base_q;
      words_d = words_q;
      c_max_d = c_max_q;
      w_max_d = w_max_q;
      r_max_d = r_max_q;
      if (init) begin
         ch_d    = '0;
         col_d   = '0;
         win_d   = '0;
         row_d   = '0;
         off_d   = '0;
         c_max_d = 4'(cfg_atlchin - 5'd1);
         w_max_d = cfg_window - 4'd1;
         r_max_d = cfg_row_cnt - 2'd1;
         slot_d  = cfg_start_slot;
         words_d = init_words;
         base_d  = ADDR_W'(cfg_start_slot) * init_words;
      end else if (step) begin
         ch_d  = ch_end ? '0 : ch_q + 4'd1;
         off_d = off_q + ADDR_W'(1);
         if (ch_end) begin
            col_d = col_end ? '0 : col_q + 2'd1;
            if (col_end) begin
               win_d = win_end ? '0 : win_q + 4'd1;
               if (win_end) begin
                  // Row finished: restart the row offset and move to the next circular slot.
                  row_d = row_q + 2'd1;
                  off_d = '0;
                  if (slot_q == 2'(NUM_ROW_SLOTS - 1)) begin
                     slot_d = '0;
                     base_d = '0;
                  end else begin
                     slot_d = slot_q + 2'd1;
                     base_d = base_q + words_q;
                  end
               end
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_q    <= '0;
         col_q   <= '0;
         win_q   <= '0;
         row_q   <= '0;
         off_q   <= '0;
         slot_q  <= '0;
         base_q  <= '0;
         words_q <= '0;
         c_max_q <= '0;
         w_max_q <= '0;
         r_max_q <= '0;
      end else begin
         ch_q    <= ch_d;
         col_q   <= col_d;
         win_q   <= win_d;
         row_q   <= row_d;
         off_q   <= off_d;
         slot_q  <= slot_d;
         base_q  <= base_d;
         words_q <= words_d;
         c_max_q <= c_max_d;
         w_max_q <= w_max_d;
         r_max_q <= r_max_d;
      end
   end

endmodule

// File: rtl/ifsram_w.sv
// ifsram write stage: streams 1..3 feature rows into the 3-row circular ifsram.
// Optional IFSRAM_W_PERF_EN adds the stall_cnt performance counter output.
module ifsram_w
   import ifsram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_write_start,
   output logic              if_write_busy,
   output logic              if_write_done,
   input  logic [3:0]        cfg_window,
   input  logic [4:0]        cfg_atlchin,
   input  logic [1:0]        cfg_row_cnt,
   input  logic [1:0]        cfg_start_slot,
   input  logic [TBITS-1:0]  s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              cen_writes_ifsram,
   output logic              wen_ifsram,
   output logic [ADDR_W-1:0] addr_write_ifsram,
   output logic [TBITS-1:0]  data_write_ifsram
`ifdef IFSRAM_W_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   iw_state_e         state_q, state_d;
   logic              init, accept, gen_last;
   logic [ADDR_W-1:0] gen_addr;
   logic              done_q, cen_q, wen_q;
   logic [ADDR_W-1:0] addr_q;
   logic [TBITS-1:0]  data_q;

   assign init          = (state_q == IW_IDLE) && if_write_start;
   assign s_ready       = (state_q == IW_WRITE);
   assign accept        = s_valid && s_ready;
   assign if_write_busy = (state_q != IW_IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IW_IDLE:  if (if_write_start) state_d = (cfg_row_cnt != 2'd0) ? IW_WRITE : IW_DONE;
         IW_WRITE: if (accept && gen_last) state_d = IW_DONE;
         IW_DONE:  state_d = IW_IDLE;
         default:  state_d = IW_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IW_IDLE;
      else       state_q <= state_d;
   end

   ifsram_w_addr_gen u_addr_gen (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .step           (accept),
      .cfg_window     (cfg_window),
      .cfg_atlchin    (cfg_atlchin),
      .cfg_row_cnt    (cfg_row_cnt),
      .cfg_start_slot (cfg_start_slot),
      .addr           (gen_addr),
      .last           (gen_last)
   );

   // SRAM port is fully registered: an accepted beat appears exactly one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q <= 1'b0;
         cen_q  <= 1'b1;
         wen_q  <= 1'b1;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         done_q <= (state_q == IW_DONE);
         cen_q  <= ~accept;
         wen_q  <= ~accept;
         addr_q <= accept ? gen_addr : '0;
         data_q <= accept ? s_data : '0;
      end
   end

   assign if_write_done     = done_q;
   assign cen_writes_ifsram = cen_q;
   assign wen_ifsram        = wen_q;
   assign addr_write_ifsram = addr_q;
   assign data_write_ifsram = data_q;

`ifdef IFSRAM_W_PERF_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (init)
         stall_d = '0;
      else if ((state_q == IW_WRITE) && !s_valid && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ifsram_w.sv
// Directed bench for ifsram_w: a scoreboard of expected SRAM writes is filled at each
// load start and drained as writes appear; handshake, done timing and reset are checked.
module tb_ifsram_w;
   import ifsram_pkg::*;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [TBITS-1:0]  data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_write_start;
   logic              if_write_busy;
   logic              if_write_done;
   logic [3:0]        cfg_window;
   logic [4:0]        cfg_atlchin;
   logic [1:0]        cfg_row_cnt;
   logic [1:0]        cfg_start_slot;
   logic [TBITS-1:0]  s_data;
   logic              s_valid;
   logic              s_ready;
   logic              cen;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [TBITS-1:0]  data;
`ifdef IFSRAM_W_PERF_EN
   logic [15:0]       stall_cnt;
`endif

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   done_cnt    = 0;
   int   done_cyc    = 0;
   int   load_id     = 0;
   bit   exp_wr      = 1'b0;
   exp_t exp_q[$];

   ifsram_w dut (
      .clk               (clk),
      .reset             (reset),
      .if_write_start    (if_write_start),
      .if_write_busy     (if_write_busy),
      .if_write_done     (if_write_done),
      .cfg_window        (cfg_window),
      .cfg_atlchin       (cfg_atlchin),
      .cfg_row_cnt       (cfg_row_cnt),
      .cfg_start_slot    (cfg_start_slot),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .cen_writes_ifsram (cen),
      .wen_ifsram        (wen),
      .addr_write_ifsram (addr),
      .data_write_ifsram (data)
`ifdef IFSRAM_W_PERF_EN
      ,
      .stall_cnt         (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [TBITS-1:0] pat(input int id, input int k);
      return {16'(id), 16'hC3A5, 32'(k) * 32'h9E3779B1};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      chk("cen", 64'(cen), 64'(!exp_wr));
      chk("wen", 64'(wen), 64'(!exp_wr));
      if (exp_wr) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow: observed write with empty scoreboard, expected none (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(addr), 64'(e.addr));
            chk("wr_data", data, e.data);
         end
      end else begin
         chk("addr_idle", 64'(addr), 64'd0);
         chk("data_idle", data, 64'd0);
      end
      if (if_write_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      exp_wr = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 64'(if_write_busy), 64'd0);
      chk({tag, "_done"}, 64'(if_write_done), 64'd0);
      chk({tag, "_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_cen"}, 64'(cen), 64'd1);
      chk({tag, "_wen"}, 64'(wen), 64'd1);
      chk({tag, "_addr"}, 64'(addr), 64'd0);
      chk({tag, "_data"}, data, 64'd0);
   endtask

   task automatic run_load(input int w, input int c, input int rc, input int slot,
                           input bit gaps, input int restart_at, input int abort_at);
      int   total, left, stalls, s_cyc, k, d0, n;
      bit   v;
      exp_t e;
      total = rc * w * 3 * c;
      k = 0;
      for (int r = 0; r < rc; r++) begin
         for (int off = 0; off < w * 3 * c; off++) begin
            e.addr = ADDR_W'(((slot + r) % 3) * w * 3 * c + off);
            e.data = pat(load_id, k);
            exp_q.push_back(e);
            k++;
         end
      end
      cfg_window     = 4'(w);
      cfg_atlchin    = 5'(c);
      cfg_row_cnt    = 2'(rc);
      cfg_start_slot = 2'(slot);
      if_write_start = 1'b1;
      tick();
      if_write_start = 1'b0;
      cfg_window     = 4'($urandom_range(1, 15));
      cfg_atlchin    = 5'($urandom_range(1, 16));
      cfg_row_cnt    = 2'($urandom_range(0, 3));
      cfg_start_slot = 2'($urandom_range(0, 2));
      s_cyc = cyc;
      chk("busy_rise", 64'(if_write_busy), 64'd1);
      left   = total;
      k      = 0;
      stalls = 0;
      while (left > 0) begin
         if (k == abort_at) begin
            d0      = done_cnt;
            s_valid = 1'b0;
            reset   = 1'b1;
            #2;
            chk_reset_vals("abort");
`ifdef IFSRAM_W_PERF_EN
            chk("abort_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
            tick();
            reset = 1'b0;
            exp_q.delete();
            tick();
            tick();
            chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
            chk("abort_idle_ready", 64'(s_ready), 64'd0);
            load_id++;
            return;
         end
         chk("s_ready", 64'(s_ready), 64'd1);
         v              = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_valid        = v;
         s_data         = v ? pat(load_id, k) : {$urandom, $urandom};
         if_write_start = v && (k == restart_at);
         exp_wr         = v;
         tick();
         if_write_start = 1'b0;
         if (v) begin
            k++;
            left--;
         end else begin
            stalls++;
         end
      end
      s_valid = 1'b0;
      d0 = done_cnt;
      n  = 0;
      while ((done_cnt == d0) && (n < 8)) begin
         chk("ready_low", 64'(s_ready), 64'd0);
         if_write_start = (restart_at >= 0) && (n == 0);
         cfg_row_cnt    = 2'd1;
         tick();
         if_write_start = 1'b0;
         n++;
      end
      chk("done_seen", 64'(done_cnt - d0), 64'd1);
      chk("done_lat", 64'(done_cyc - s_cyc), 64'(total + stalls + 1));
      chk("busy_fall", 64'(if_write_busy), 64'd0);
`ifdef IFSRAM_W_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done_single", 64'(if_write_done), 64'd0);
         chk("busy_idle", 64'(if_write_busy), 64'd0);
      end
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      load_id++;
   endtask

   initial begin
      reset          = 1'b0;
      if_write_start = 1'b0;
      cfg_window     = 4'd1;
      cfg_atlchin    = 5'd1;
      cfg_row_cnt    = 2'd0;
      cfg_start_slot = 2'd0;
      s_data         = '0;
      s_valid        = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      tick();
      chk_reset_vals("reset");
      reset = 1'b0;
      tick();

      // Full three-row load with a continuous stream: addr 0..71, done 74 cycles after start.
      run_load(2, 4, 3, 0, 1'b0, -1, -1);
      // Two rows from slot 2: 12..17 then wrap to 0..5.
      run_load(1, 2, 2, 2, 1'b0, -1, -1);
      // Same geometry as the first load with random stream gaps.
      run_load(2, 4, 3, 0, 1'b1, -1, -1);
      // Gapped load that wraps slots mid-load.
      run_load(3, 3, 3, 2, 1'b1, -1, -1);
      // Zero rows: done two cycles after start, no writes.
      run_load(3, 2, 0, 1, 1'b0, -1, -1);
      // Start re-pulsed at beat 5, reset asserted at beat 10.
      run_load(2, 4, 3, 1, 1'b0, 5, 10);
      // Fresh load after the abort, with start pulses in WRITE and DONE ignored.
      run_load(2, 4, 3, 1, 1'b0, 7, -1);
      // Widest row from slot 2: last address 539.
      run_load(15, 4, 1, 2, 1'b0, -1, -1);
      // Maximum channel count with gaps.
      run_load(1, 16, 2, 1, 1'b1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
